// File: rtl/nco_sweep_ctrl.sv
`default_nettype none
// ==== nco_sweep_ctrl : stepped phase-increment (chirp) sequencer for an NCO == rev 1.0 ====
// Optional macro NCO_SWEEP_LOOP_EN adds loop_i, which makes the sweep repeat until aborted.
module nco_sweep_ctrl #(
  parameter int APR     = 16,
  parameter int DWW     = 16,
  parameter int NCO_LAT = 12
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [APR-1:0] cfg_start_i,
  input  logic [APR-1:0] cfg_stop_i,
  input  logic [APR-1:0] cfg_step_i,
  input  logic [DWW-1:0] cfg_dwell_i,
  input  logic           start_i,
  input  logic           abort_i,
`ifdef NCO_SWEEP_LOOP_EN
  input  logic           loop_i,
`endif
  input  logic           nco_out_valid_i,
  output logic           nco_clken_o,
  output logic [APR-1:0] phi_inc_o,
  output logic           step_strobe_o,
  output logic           busy_o,
  output logic           done_o
);

  localparam int LW = $clog2(NCO_LAT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_SWEEP = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [LW-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DWW-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [DWW-1:0] dwell_last_q, dwell_last_d;
  logic [APR-1:0] start_q, start_d;
  logic [APR-1:0] stop_q, stop_d;
  logic [APR-1:0] step_q, step_d;
  logic           up_q, up_d;
  logic [APR-1:0] phi_q, phi_d;
  logic           clken_q, clken_d;
  logic           strobe_q, strobe_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           loop_en;

`ifdef NCO_SWEEP_LOOP_EN
  logic loop_q, loop_d;
  assign loop_en = loop_q;
`else
  assign loop_en = 1'b0;
`endif

  // One extra bit exposes carry/borrow so the increment can never wrap.
  logic [APR:0]   sum_w, diff_w;
  logic [APR-1:0] next_w;
  logic           at_end_w;

  always_comb begin
    sum_w  = {1'b0, phi_q} + {1'b0, step_q};
    diff_w = {1'b0, phi_q} - {1'b0, step_q};
    if (up_q)
      next_w = (sum_w[APR] || (sum_w[APR-1:0] > stop_q)) ? stop_q : sum_w[APR-1:0];
    else
      next_w = (diff_w[APR] || (diff_w[APR-1:0] < stop_q)) ? stop_q : diff_w[APR-1:0];
    at_end_w = (phi_q == stop_q) || (step_q == '0);
  end

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    dwell_cnt_d  = dwell_cnt_q;
    dwell_last_d = dwell_last_q;
    start_d      = start_q;
    stop_d       = stop_q;
    step_d       = step_q;
    up_d         = up_q;
    phi_d        = phi_q;
    strobe_d     = 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
    loop_d       = loop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          start_d      = cfg_start_i;
          stop_d       = cfg_stop_i;
          step_d       = cfg_step_i;
          dwell_last_d = (cfg_dwell_i == '0) ? '0 : cfg_dwell_i - DWW'(1);
          up_d         = (cfg_stop_i >= cfg_start_i);
`ifdef NCO_SWEEP_LOOP_EN
          loop_d       = loop_i;
`endif
          phi_d        = cfg_start_i;
          lat_cnt_d    = '0;
          state_d      = S_PRIME;
        end
      end
      S_PRIME: begin
        if (lat_cnt_q == LW'(NCO_LAT - 1)) begin
          lat_cnt_d   = '0;
          dwell_cnt_d = '0;
          state_d     = S_SWEEP;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      S_SWEEP: begin
        if (nco_out_valid_i) begin
          if (dwell_cnt_q == dwell_last_q) begin
            dwell_cnt_d = '0;
            if (at_end_w) begin
              if (loop_en) begin
                phi_d    = start_q;
                strobe_d = 1'b1;
              end else begin
                lat_cnt_d = '0;
                state_d   = S_DRAIN;
              end
            end else begin
              phi_d    = next_w;
              strobe_d = 1'b1;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (lat_cnt_q == LW'(NCO_LAT - 1)) begin
          lat_cnt_d = '0;
          state_d   = S_DONE;
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      phi_d       = phi_q;
      strobe_d    = 1'b0;
      lat_cnt_d   = '0;
      dwell_cnt_d = '0;
    end

    // Status outputs are decoded from the next state so they line up with it.
    clken_d = (state_d == S_PRIME) || (state_d == S_SWEEP) || (state_d == S_DRAIN);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      lat_cnt_q    <= '0;
      dwell_cnt_q  <= '0;
      dwell_last_q <= '0;
      start_q      <= '0;
      stop_q       <= '0;
      step_q       <= '0;
      up_q         <= 1'b0;
      phi_q        <= '0;
      clken_q      <= 1'b0;
      strobe_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
      loop_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      dwell_cnt_q  <= dwell_cnt_d;
      dwell_last_q <= dwell_last_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      step_q       <= step_d;
      up_q         <= up_d;
      phi_q        <= phi_d;
      clken_q      <= clken_d;
      strobe_q     <= strobe_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef NCO_SWEEP_LOOP_EN
      loop_q       <= loop_d;
`endif
    end
  end

  assign nco_clken_o   = clken_q;
  assign phi_inc_o     = phi_q;
  assign step_strobe_o = strobe_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_nco_sweep_ctrl.sv
`default_nettype none
// Bench for nco_sweep_ctrl: per-cycle comparison against a timeline computed from the sweep rules.
module tb_nco_sweep_ctrl;
  localparam int APR  = 16;
  localparam int DWW  = 16;
  localparam int L    = 12;
  localparam int VMAX = 1024;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [APR-1:0] cfg_start_i = '0, cfg_stop_i = '0, cfg_step_i = '0;
  logic [DWW-1:0] cfg_dwell_i = '0;
  logic           start_i = 1'b0, abort_i = 1'b0, nco_out_valid_i = 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
  logic           loop_i = 1'b0;
`endif
  logic           nco_clken_o, step_strobe_o, busy_o, done_o;
  logic [APR-1:0] phi_inc_o;

  always #5 clk = ~clk;

  nco_sweep_ctrl #(.APR(APR), .DWW(DWW), .NCO_LAT(L)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_step_i(cfg_step_i),
    .cfg_dwell_i(cfg_dwell_i), .start_i(start_i), .abort_i(abort_i),
`ifdef NCO_SWEEP_LOOP_EN
    .loop_i(loop_i),
`endif
    .nco_out_valid_i(nco_out_valid_i), .nco_clken_o(nco_clken_o), .phi_inc_o(phi_inc_o),
    .step_strobe_o(step_strobe_o), .busy_o(busy_o), .done_o(done_o)
  );

  int total = 0;
  int bad   = 0;
  bit v[VMAX];
  int seq[$];
  int starts[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic sweep: start, start+-step, ... ; final entry is always stop.
  task automatic build_seq(input int st, input int sp, input int stp);
    int diff, n;
    seq.delete();
    diff = (sp >= st) ? sp - st : st - sp;
    if (stp == 0 || diff == 0) begin
      seq.push_back(st);
      return;
    end
    n = (diff + stp - 1) / stp + 1;
    for (int i = 0; i < n - 1; i++) seq.push_back((sp >= st) ? st + i * stp : st - i * stp);
    seq.push_back(sp);
  endtask

  // mode 0: valid always 1; mode 1: toggles 1,0 from first sweep cycle; mode 2: random
  task automatic run_sweep(input string name, input int st, input int sp, input int stp,
                           input int dw, input int mode);
    int d, t, cnt, k, e_last;
    bit strobe_exp;
    build_seq(st, sp, stp);
    for (int i = 0; i < VMAX; i++) begin
      case (mode)
        0:       v[i] = 1'b1;
        1:       v[i] = (i >= L) ? (((i - L) % 2) == 0) : 1'b0;
        default: v[i] = ($urandom_range(0, 2) != 0) || ((i % 2) == 0);
      endcase
    end
    d = (dw == 0) ? 1 : dw;
    t = L;
    starts.delete();
    foreach (seq[j]) begin
      starts.push_back(t);
      cnt = 0;
      forever begin
        if (v[t]) cnt++;
        if (cnt == d) break;
        t++;
      end
      t++;
    end
    e_last = t - 1;

    @(negedge clk);
    cfg_start_i = APR'(st); cfg_stop_i = APR'(sp); cfg_step_i = APR'(stp);
    cfg_dwell_i = DWW'(dw); start_i = 1'b1; nco_out_valid_i = 1'b0;
    for (int tc = 0; tc <= e_last + L + 2; tc++) begin
      @(negedge clk);
      start_i = 1'b0;
      k = 0;
      strobe_exp = 1'b0;
      for (int j = 0; j < starts.size(); j++) begin
        if (starts[j] <= tc) k = j;
        if (j > 0 && starts[j] == tc) strobe_exp = 1'b1;
      end
      check($sformatf("%s phi t=%0d", name, tc), 32'(phi_inc_o), 32'(seq[k]));
      check($sformatf("%s strobe t=%0d", name, tc), 32'(step_strobe_o), 32'(strobe_exp));
      check($sformatf("%s clken t=%0d", name, tc), 32'(nco_clken_o), 32'(tc <= e_last + L));
      check($sformatf("%s busy t=%0d", name, tc), 32'(busy_o), 32'(tc <= e_last + L + 1));
      check($sformatf("%s done t=%0d", name, tc), 32'(done_o), 32'(tc == e_last + L + 1));
      nco_out_valid_i = v[tc];
    end
    nco_out_valid_i = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int st, sp, stp, diff, r;
    #1;
    check("reset clken", 32'(nco_clken_o), 32'd0);
    check("reset phi",   32'(phi_inc_o),   32'd0);
    check("reset busy",  32'(busy_o),      32'd0);
    check("reset done",  32'(done_o),      32'd0);
    check("reset strobe", 32'(step_strobe_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_sweep("up",     100, 400, 100, 4, 0);
    run_sweep("down",   1000, 10, 300, 2, 0);
    run_sweep("top",    32'hFF00, 32'hFFFF, 32'h0080, 0, 0);
    run_sweep("toggle", 100, 400, 100, 3, 1);
    run_sweep("single", 50, 50, 7, 2, 2);
    run_sweep("step0",  300, 900, 0, 1, 2);

    for (int n = 0; n < 6; n++) begin
      st = int'($urandom_range(0, 65535));
      sp = int'($urandom_range(0, 65535));
      diff = (sp >= st) ? sp - st : st - sp;
      r = int'($urandom_range(1, 7));
      stp = diff / r + int'($urandom_range(1, 40));
      run_sweep($sformatf("rnd%0d", n), st, sp, stp, int'($urandom_range(0, 5)), 2);
    end

    // Abort mid-sweep; a start while busy must not relatch configuration.
    @(negedge clk);
    cfg_start_i = 16'd100; cfg_stop_i = 16'd400; cfg_step_i = 16'd100; cfg_dwell_i = 16'd4;
    start_i = 1'b1; nco_out_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (L + 1) @(negedge clk);
    cfg_start_i = 16'd7; cfg_step_i = 16'd1; start_i = 1'b1;
    check("busy-start phi", 32'(phi_inc_o), 32'd100);
    @(negedge clk);
    start_i = 1'b0;
    check("busy-start busy", 32'(busy_o), 32'd1);
    repeat (3) @(negedge clk);
    check("busy-start step kept", 32'(phi_inc_o), 32'd200);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    check("abort clken", 32'(nco_clken_o), 32'd0);
    check("abort busy",  32'(busy_o),      32'd0);
    check("abort done",  32'(done_o),      32'd0);
    check("abort phi",   32'(phi_inc_o),   32'd200);
    check("abort strobe", 32'(step_strobe_o), 32'd0);
    for (int i = 0; i < L + 4; i++) begin
      @(negedge clk);
      check($sformatf("post-abort done c=%0d", i), 32'(done_o), 32'd0);
    end
    nco_out_valid_i = 1'b0;

    // start and abort together in IDLE: abort wins.
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    check("start+abort busy",  32'(busy_o),      32'd0);
    check("start+abort clken", 32'(nco_clken_o), 32'd0);
    run_sweep("after-abort", 20, 80, 30, 1, 2);

    // Asynchronous reset mid-sweep.
    @(negedge clk);
    cfg_start_i = 16'd100; cfg_stop_i = 16'd400; cfg_step_i = 16'd100; cfg_dwell_i = 16'd2;
    start_i = 1'b1; nco_out_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (L + 4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst phi",   32'(phi_inc_o),   32'd0);
    check("midrst busy",  32'(busy_o),      32'd0);
    check("midrst clken", 32'(nco_clken_o), 32'd0);
    check("midrst strobe", 32'(step_strobe_o), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < L + 4; i++) begin
      @(negedge clk);
      check($sformatf("post-rst idle c=%0d", i), 32'({busy_o, done_o}), 32'd0);
    end
    nco_out_valid_i = 1'b0;

`ifdef NCO_SWEEP_LOOP_EN
    @(negedge clk);
    cfg_start_i = 16'd5; cfg_stop_i = 16'd15; cfg_step_i = 16'd5; cfg_dwell_i = 16'd1;
    loop_i = 1'b1; start_i = 1'b1; nco_out_valid_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; loop_i = 1'b0;
    repeat (L) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("loop phi i=%0d", i), 32'(phi_inc_o), 32'(5 * ((i % 3) + 1)));
      check($sformatf("loop strobe i=%0d", i), 32'(step_strobe_o), 32'(i > 0));
      check($sformatf("loop done i=%0d", i), 32'(done_o), 32'd0);
      @(negedge clk);
    end
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0; nco_out_valid_i = 1'b0;
    check("loop abort busy", 32'(busy_o), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives the NCO phase-increment input and clock-enable to produce a stepped frequency sweep (chirp) from a start to a stop increment. Each step is held for a programmable number of valid NCO output samples. The block sits between the register/config interface and the NCO core, consuming the NCO out_valid flag. Configuration is latched on start; a sweep runs to completion or abort, with the pipeline primed and drained around it.

Parameters:
APR, 16, phase-increment width; matches NCO apr.
DWW, 16, dwell counter width.
NCO_LAT, 12, NCO clken-cycles from a phi_inc change to the corresponding output sample.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cfg_start_i  in  APR  first phase increment (unsigned)
cfg_stop_i  in  APR  last phase increment (unsigned)
cfg_step_i  in  APR  step magnitude (unsigned)
cfg_dwell_i  in  DWW  valid samples per step; 0 treated as 1
start_i  in  1  begin sweep (sampled in IDLE only)
abort_i  in  1  terminate sweep
nco_out_valid_i  in  1  NCO out_valid
nco_clken_o  out  1  NCO clken
phi_inc_o  out  APR  NCO phi_inc_i
step_strobe_o  out  1  1-cycle pulse when phi_inc_o changes to a new step
busy_o  out  1  high in any state other than IDLE
done_o  out  1  1-cycle pulse on normal completion

Behaviour:
- Reset: all outputs 0; state IDLE; internal counters 0.
- States: IDLE, PRIME, SWEEP, DRAIN, DONE. Every output is registered.
- IDLE: nco_clken_o=0. phi_inc_o holds its last value. On start_i=1, latch all cfg_* inputs. Direction: up if stop>=start, else down. Next state is PRIME, and phi_inc_o<=start. start_i is ignored outside IDLE.
- PRIME: nco_clken_o=1. Count NCO_LAT cycles, then go to SWEEP with dwell_cnt=0.
- SWEEP: nco_clken_o=1. dwell_cnt increments only on cycles with nco_out_valid_i=1. On a valid cycle where dwell_cnt==dwell-1:
  - If phi_inc_o==stop, or step==0: go to DRAIN.
  - Otherwise: phi_inc_o<=next, step_strobe_o=1 for one cycle, dwell_cnt<=0.
- next computation: computed in APR+1 bits as phi+step (up) or phi-step (down). Clamp to stop if it passes stop, or on carry/borrow. phi_inc_o never wraps and never goes beyond stop.
- DRAIN: nco_clken_o=1. Count NCO_LAT cycles so the last step's samples emerge, then go to DONE.
- DONE: done_o=1 for exactly one cycle, nco_clken_o=0, then go to IDLE.
- abort_i: highest priority in every non-IDLE state. Next cycle: state IDLE, nco_clken_o=0, busy_o=0, done_o stays 0, phi_inc_o unchanged. If start_i and abort_i are high in the same IDLE cycle, abort wins and no sweep starts.
- Sample count per step equals dwell exactly, because nco_out_valid_i=0 cycles do not count.
- Number of steps = ceil(|stop-start|/step)+1. start==stop gives one step.
- Reset asserted mid-sweep: immediate return to reset values. No done_o.

Optional Feature:
NCO_SWEEP_LOOP_EN.
- Defined: adds input port loop_i (1 bit, latched with the config at start). If latched loop_i=1, reaching the end of the stop step reloads phi_inc_o<=start, pulses step_strobe_o, and stays in SWEEP with no DRAIN or PRIME. This repeats until abort_i. done_o never pulses in loop mode.
- Undefined: no loop_i port; every sweep is single-shot as described above.

Test Plan:
- start=100, stop=400, step=100, dwell=4, out_valid tied 1 -> phi_inc_o sequence 100,200,300,400. Each value held for 4 SWEEP cycles; 3 step_strobe_o pulses. done_o fires NCO_LAT+1 cycles after the last dwell ends. busy_o=0 the cycle after that.
- start=1000, stop=10, step=300 (down, clamped) -> sequence 1000,700,400,100,10, then done_o.
- start=0xFF00, stop=0xFFFF, step=0x0080 -> sequence 0xFF00,0xFF80,0xFFFF with no wrap. dwell=0 behaves as dwell=1.
- dwell=3, out_valid toggling 1,0,1,0 -> each step lasts exactly 3 high cycles of out_valid (6 clk).
- abort_i asserted mid-SWEEP -> next cycle nco_clken_o=0, busy_o=0, no done_o. A start_i issued 1 cycle later begins a new PRIME. start_i pulsed while busy has no effect.
- With NCO_SWEEP_LOOP_EN and loop_i=1, start=5, stop=15, step=5 -> sequence 5,10,15,5,10,... with no done_o until abort.
